// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog -- programmable, glitch-free integer clock divider.
//
// Produces clk_o = clk_i / div_q with a 50 % duty cycle for even and odd
// ratios (odd ratios use a negedge-delayed copy of the phase to get half-cycle
// resolution). Ratio changes and enable/disable only take effect at the end of
// an output period, so clk_o never produces a runt pulse. Every gate/mux on
// the clock path is a tc_clk_mux2 / tc_clk_buf cell.
//
// Ports:
//   clk_i        source clock (only clock of the block)
//   rst_ni       asynchronous active-low reset
//   en_i         output enable; 0 parks clk_o low after the current period
//   div_i        requested divisor (0 is treated as 1)
//   div_valid_i  divisor request valid (requester holds it until accepted)
//   div_ready_o  request can be accepted (no divisor pending)
//   period_o     one-cycle strobe in the first source cycle of each period
//   clk_o        divided clock
//
// en_i is also looked at on the falling edge of clk_i (to gate the bypass
// path), so it must be settled within the first half of the source cycle.
// ---------------------------------------------------------------------------

// Behavioural models of the technology clock cells. The library versions
// replace these at implementation time.
module tc_clk_mux2 (
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic clk_sel_i,
    output logic clk_o
);
    assign clk_o = clk_sel_i ? clk1_i : clk0_i;
endmodule

module tc_clk_buf (
    input  logic clk_i,
    output logic clk_o
);
    assign clk_o = clk_i;
endmodule

module clk_div_prog #(
    parameter int unsigned DIV_WIDTH   = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    output logic                 period_o,
    output logic                 clk_o
);
    localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH:0]   ONE_W     = (DIV_WIDTH+1)'(1);

    // Posedge state
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] div_pend_q, div_pend_d;
    logic                 pend_v_q, pend_v_d;
    logic                 gate_q, gate_d;
    logic                 clk_a_q, clk_a_d;

    // Negedge state (clock-path selects and the delayed phase)
    logic                 clk_b_q;
    logic                 odd_sel_q;
    logic                 byp_sel_q;
    logic                 byp_gate_q;

    logic                 boundary;
    logic                 accept;
    logic [DIV_WIDTH:0]   half_hi;

    // Clock-path nets
    logic                 clk_ab;
    logic                 clk_div;
    logic                 clk_byp;
    logic                 clk_mux;

    assign div_ready_o = !pend_v_q;
    assign period_o    = gate_q && (cnt_q == '0);

    always_comb begin
        // While gated off every cycle is a boundary, so cnt stays at 0 and a
        // re-enable starts a fresh period immediately.
        boundary   = !gate_q || (cnt_q == div_q - DIV_ONE);
        accept     = div_valid_i && !pend_v_q;

        cnt_d      = cnt_q + DIV_ONE;
        div_d      = div_q;
        div_pend_d = div_pend_q;
        pend_v_d   = pend_v_q;
        gate_d     = gate_q;

        if (boundary) begin
            cnt_d  = '0;
            gate_d = en_i;
            if (pend_v_q) begin
                div_d    = div_pend_q;
                pend_v_d = 1'b0;
            end
        end

        // Accept and apply are mutually exclusive (accept needs !pend_v,
        // apply needs pend_v), so a request arriving on a boundary is only
        // captured and applies at the following boundary.
        if (accept) begin
            pend_v_d   = 1'b1;
            div_pend_d = (div_i == '0) ? DIV_ONE : div_i;
        end

        // High for ceil(div/2) source cycles; the odd case is trimmed by half
        // a cycle by ANDing with the negedge copy. In bypass the phase is
        // held low so the divided path is quiet while the mux points at clk_i.
        half_hi = ({1'b0, div_d} + ONE_W) >> 1;
        clk_a_d = gate_d && (div_d != DIV_ONE) && ({1'b0, cnt_d} < half_hi);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            div_q      <= DIV_RESET;
            div_pend_q <= '0;
            pend_v_q   <= 1'b0;
            gate_q     <= 1'b0;
            clk_a_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            div_pend_q <= div_pend_d;
            pend_v_q   <= pend_v_d;
            gate_q     <= gate_d;
            clk_a_q    <= clk_a_d;
        end
    end

    // The selects are loaded on the falling edge that precedes the boundary
    // posedge, using the next-state values. At that instant clk_i is low and
    // clk_a is low (end of the low phase, or gated), so every mux changes
    // select only while both of its data inputs are low.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_b_q    <= 1'b0;
            odd_sel_q  <= 1'b0;
            byp_sel_q  <= 1'b0;
            byp_gate_q <= 1'b0;
        end else begin
            clk_b_q    <= clk_a_q;
            if (boundary) begin
                odd_sel_q <= div_d[0];
            end
            byp_sel_q  <= (div_d == DIV_ONE);
            byp_gate_q <= gate_d && (div_d == DIV_ONE);
        end
    end

    // clk_a & clk_b
    tc_clk_mux2 u_mux_and (
        .clk0_i    (1'b0),
        .clk1_i    (clk_b_q),
        .clk_sel_i (clk_a_q),
        .clk_o     (clk_ab)
    );

    // even ratio: clk_a, odd ratio: clk_a & clk_b
    tc_clk_mux2 u_mux_odd (
        .clk0_i    (clk_a_q),
        .clk1_i    (clk_ab),
        .clk_sel_i (odd_sel_q),
        .clk_o     (clk_div)
    );

    // gated clk_i for the divide-by-1 path
    tc_clk_mux2 u_mux_gate (
        .clk0_i    (1'b0),
        .clk1_i    (clk_i),
        .clk_sel_i (byp_gate_q),
        .clk_o     (clk_byp)
    );

    // divided path vs bypass
    tc_clk_mux2 u_mux_byp (
        .clk0_i    (clk_div),
        .clk1_i    (clk_byp),
        .clk_sel_i (byp_sel_q),
        .clk_o     (clk_mux)
    );

    tc_clk_buf u_buf_out (
        .clk_i (clk_mux),
        .clk_o (clk_o)
    );
endmodule

// File: tb/tb_clk_div_prog.sv
// ---------------------------------------------------------------------------
// Testbench for clk_div_prog. clk_o is sampled in the middle of the high and
// the low half of every source cycle and compared, together with period_o and
// div_ready_o, against a period-level reference model: at each period start
// the model lays out the whole expected waveform of that period.
// ---------------------------------------------------------------------------
module tb_clk_div_prog;
    localparam int DW  = 8;
    localparam int DEF = 4;

    logic          clk_i;
    logic          rst_ni;
    logic          en_i;
    logic [DW-1:0] div_i;
    logic          div_valid_i;
    logic          div_ready_o;
    logic          period_o;
    logic          clk_o;

    int errors = 0;
    int checks = 0;

    clk_div_prog #(
        .DIV_WIDTH   (DW),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .div_i       (div_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .period_o    (period_o),
        .clk_o       (clk_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // ---------------- reference model ----------------
    // Expected value of one source cycle: clk_o in high half, in low half,
    // and period_o.
    typedef struct packed {
        logic h;
        logic l;
        logic p;
    } rec_t;

    rec_t per_q[$];   // remaining cycles of the current output period
    rec_t cur;        // expectation for the cycle in progress
    int   m_div;
    int   m_pend;
    bit   m_pend_v;
    int   m_idx;      // index of the current cycle inside its period

    function automatic void model_reset();
        per_q.delete();
        cur      = '0;
        m_div    = DEF;
        m_pend   = 0;
        m_pend_v = 1'b0;
        m_idx    = 0;
    endfunction

    // Waveform of one full period of ratio n, cycle by cycle.
    function automatic void push_period(input int n);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            r.p = (i == 0);
            if (n == 1) begin
                r.h = 1'b1;           // clk_o follows clk_i
                r.l = 1'b0;
            end else if (n % 2 == 0) begin
                r.h = (i < n / 2);
                r.l = (i < n / 2);
            end else begin
                // high from the middle of cycle 0 for n/2 cycles
                r.l = (i < (n + 1) / 2);
                r.h = (i >= 1) && (i < (n + 1) / 2);
            end
            per_q.push_back(r);
        end
    endfunction

    // Advance the model by one source posedge; returns 1 if the request
    // presented at this edge was accepted.
    function automatic bit model_edge(input bit en, input bit valid, input int div);
        bit   acc;
        rec_t z;
        z   = '0;
        acc = valid && !m_pend_v;
        if (per_q.size() == 0) begin
            if (m_pend_v) begin
                m_div    = m_pend;
                m_pend_v = 1'b0;
            end
            if (en) push_period(m_div);
            else    per_q.push_back(z);
            m_idx = 0;
        end else begin
            m_idx++;
        end
        cur = per_q.pop_front();
        if (acc) begin
            m_pend_v = 1'b1;
            m_pend   = (div == 0) ? 1 : div;
        end
        return acc;
    endfunction

    // ---------------- cycle driver ----------------
    // Entered 3 time units after a posedge; drives the inputs for the next
    // edge, checks the low half of the current cycle, then the high half,
    // period_o and div_ready_o of the next one.
    task automatic step(input bit en, input bit valid, input int div, output bit acc);
        en_i        = en;
        div_valid_i = valid;
        div_i       = div[DW-1:0];
        @(negedge clk_i);
        #2;
        checks++;
        if (clk_o !== cur.l) begin
            errors++;
            $display("FAIL clk_o_low t=%0t got=%b exp=%b div=%0d idx=%0d", $time, clk_o, cur.l, m_div, m_idx);
        end
        @(posedge clk_i);
        acc = model_edge(en, valid, div);
        #2;
        checks++;
        if (clk_o !== cur.h) begin
            errors++;
            $display("FAIL clk_o_high t=%0t got=%b exp=%b div=%0d idx=%0d", $time, clk_o, cur.h, m_div, m_idx);
        end
        checks++;
        if (period_o !== cur.p) begin
            errors++;
            $display("FAIL period_o t=%0t got=%b exp=%b div=%0d idx=%0d", $time, period_o, cur.p, m_div, m_idx);
        end
        checks++;
        if (div_ready_o !== !m_pend_v) begin
            errors++;
            $display("FAIL div_ready t=%0t got=%b exp=%b", $time, div_ready_o, !m_pend_v);
        end
        #1;
    endtask

    task automatic run(input int n, input bit en);
        bit acc;
        for (int i = 0; i < n; i++) step(en, 1'b0, 0, acc);
    endtask

    // Present a divisor request and hold it until accepted.
    task automatic request(input int div, input int bound);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < bound) begin
            step(1'b1, 1'b1, div, acc);
            n++;
        end
        if (!acc) begin
            errors++;
            $display("FAIL req_timeout div=%0d got=not_accepted exp=accepted_within_%0d", div, bound);
        end
    endtask

    // Run enabled until the current cycle is cycle idx of a div-period.
    task automatic wait_phase(input int div, input int idx, input int bound);
        int n;
        n = 0;
        while (!(m_div == div && m_idx == idx && cur.p == (idx == 0) && n < bound && !m_pend_v)) begin
            run(1, 1'b1);
            n++;
        end
        if (n >= bound) begin
            errors++;
            $display("FAIL phase_timeout got=div%0d/idx%0d exp=div%0d/idx%0d", m_div, m_idx, div, idx);
        end
    endtask

    task automatic check_in_reset(input string tag);
        #1;
        checks++;
        if (clk_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_clk_o got=%b exp=0", tag, clk_o);
        end
        checks++;
        if (period_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_period_o got=%b exp=0", tag, period_o);
        end
        checks++;
        if (div_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_div_ready got=%b exp=1", tag, div_ready_o);
        end
    endtask

    task automatic release_reset();
        @(posedge clk_i);
        @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_ni      = 1'b1;
        en_i        = 1'b1;
        div_valid_i = 1'b0;
        div_i       = '0;
        #2;
        rst_ni = 1'b0;
        check_in_reset("reset");
        release_reset();
        run(12, 1'b1);
        $display("test_reset: default ratio %0d, checks=%0d errors=%0d", DEF, checks, errors);
    endtask

    task automatic test_div3();
        request(3, 8);
        run(12, 1'b1);
        $display("test_div3: odd ratio 3, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_back_to_back();
        bit acc;
        request(4, 8);
        wait_phase(4, 1, 20);
        step(1'b1, 1'b1, 6, acc);   // accepted at cnt=1
        request(2, 20);             // blocked until 6 is applied
        run(14, 1'b1);
        $display("test_back_to_back: 6 then 2, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_bypass();
        request(0, 8);
        run(8, 1'b1);
        request(5, 8);
        run(15, 1'b1);
        $display("test_bypass: 0 (bypass) then 5, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_gating();
        request(8, 8);
        wait_phase(8, 0, 20);
        run(16, 1'b0);              // dropped at cnt=0: period finishes, then parked
        run(12, 1'b1);
        $display("test_gating: div 8 disable/enable, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_mid();
        bit acc;
        wait_phase(8, 0, 20);
        step(1'b1, 1'b1, 6, acc);   // pending divisor, still in high phase
        if (!(cur.h && m_pend_v)) begin
            errors++;
            $display("FAIL reset_mid_setup got=h%b/pend%b exp=h1/pend1", cur.h, m_pend_v);
        end
        rst_ni = 1'b0;
        check_in_reset("reset_mid");
        release_reset();
        run(12, 1'b1);
        $display("test_reset_mid: async reset with pending divisor, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_random();
        bit acc;
        bit req_on;
        int req_div;
        bit en;
        req_on  = 1'b0;
        req_div = 0;
        for (int i = 0; i < 700; i++) begin
            if (!req_on && $urandom_range(0, 7) == 0) begin
                req_on  = 1'b1;
                req_div = $urandom_range(0, 9);
            end
            en = ($urandom_range(0, 9) != 0);
            step(en, req_on, req_on ? req_div : int'($urandom_range(0, 255)), acc);
            if (acc) req_on = 1'b0;
        end
        $display("test_random: 700 cycles, checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_div3();
        test_back_to_back();
        test_bypass();
        test_gating();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
